// File: rtl/ifu_fetch.sv
// ifu_fetch: YPC instruction fetch unit; one outstanding imem read, redirect with stale-response kill (IFU_ALIGN_CHECK_EN enables misaligned-redirect trap)
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        fetch_misalign
);
  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;
  logic [1:0]  state;
  logic [31:0] pc, inst_q, inst_pc_q, redir_pc;
  logic        kill, redir, bad;
`ifdef IFU_ALIGN_CHECK_EN
  logic misalign_q;
  assign redir          = redirect_valid && state != S_ERR;
  assign bad            = redir && |redirect_pc[1:0];
  assign redir_pc       = redirect_pc;
  assign fetch_misalign = !rst && misalign_q;
  // sticky misaligned-target flag, cleared only by reset
  always_ff @(posedge clk)
    if (rst) misalign_q <= 1'b0;
    else if (bad) misalign_q <= 1'b1;
`else
  assign redir          = redirect_valid;
  assign bad            = 1'b0;
  assign redir_pc       = redirect_pc & ~32'h3;
  assign fetch_misalign = 1'b0;
`endif
  assign imem_req_valid = !rst && state == S_REQ;
  assign imem_req_addr  = rst ? RESET_PC : pc;
  assign inst_valid     = !rst && state == S_HOLD && !redirect_valid;
  assign inst           = rst ? 32'h0 : inst_q;
  assign inst_pc        = rst ? 32'h0 : inst_pc_q;
  // fetch FSM; a redirect overrides every other event and marks any in-flight read stale
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      state     <= S_REQ;
      kill      <= 1'b0;
      inst_q    <= 32'h0;
      inst_pc_q <= 32'h0;
    end else if (redir) begin
      pc    <= redir_pc;
      state <= bad ? S_ERR :
               state == S_REQ  ? (imem_req_ready ? S_WAIT : S_REQ) :
               state == S_WAIT ? (imem_rsp_valid ? S_REQ : S_WAIT) : S_REQ;
      kill  <= !bad && ((state == S_REQ && imem_req_ready) || (state == S_WAIT && !imem_rsp_valid));
    end else if (state == S_REQ && imem_req_ready) begin
      state <= S_WAIT;
    end else if (state == S_WAIT && imem_rsp_valid) begin
      state <= kill ? S_REQ : S_HOLD;
      kill  <= 1'b0;
      if (!kill) begin
        inst_q    <= imem_rsp_data;
        inst_pc_q <= pc;
      end
    end else if (state == S_HOLD && inst_ready) begin
      pc    <= pc + 32'd4;
      state <= S_REQ;
    end
  end
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: table-driven cycle vectors for ifu_fetch plus misalign/reset sequences
module tb_ifu_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [31:0] inst, inst_pc;
  logic        fetch_misalign;
  int tests = 0, fails = 0;
`ifdef IFU_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  typedef struct {
    bit r, rr, rv; logic [31:0] rd; bit dv; logic [31:0] dp; bit ir;
    bit eq; logic [31:0] ea; bit ev; logic [31:0] ei, ep; bit em;
  } vec_t;
  vec_t vq[$];

  ifu_fetch dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .fetch_misalign(fetch_misalign)
  );

  always #5 clk = ~clk;

  task automatic add(input bit r, rr, rv, input logic [31:0] rd, input bit dv, input logic [31:0] dp,
                     input bit ir, eq, input logic [31:0] ea, input bit ev, input logic [31:0] ei, ep);
    vq.push_back('{r, rr, rv, rd, dv, dp, ir, eq, ea, ev, ei, ep, 1'b0});
  endtask

  task automatic chk(input string n, input int idx, input logic [31:0] got, exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL step %0d %s: got %h expected %h", idx, n, got, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    rst = v.r; imem_req_ready = v.rr; imem_rsp_valid = v.rv; imem_rsp_data = v.rd;
    redirect_valid = v.dv; redirect_pc = v.dp; inst_ready = v.ir;
    #1;
    chk("imem_req_valid", idx, {31'b0, imem_req_valid}, {31'b0, v.eq});
    chk("imem_req_addr", idx, imem_req_addr, v.ea);
    chk("inst_valid", idx, {31'b0, inst_valid}, {31'b0, v.ev});
    chk("fetch_misalign", idx, {31'b0, fetch_misalign}, {31'b0, v.em});
    if (v.ev || v.r) begin
      chk("inst", idx, inst, v.ei);
      chk("inst_pc", idx, inst_pc, v.ep);
    end
  endtask

  initial begin
    //   r rr rv rd            dv dp            ir  eq ea            ev ei            ep
    add(1, 0, 0, 32'h0,        0, 32'h0,        0,  0, 32'h80000000, 0, 32'h0,        32'h0);
    add(1, 0, 0, 32'h0,        0, 32'h0,        0,  0, 32'h80000000, 0, 32'h0,        32'h0);
    // zero-wait stream, one instruction per 3 cycles
    add(0, 1, 0, 32'h0,        0, 32'h0,        1,  1, 32'h80000000, 0, 32'h0,        32'h0);
    add(0, 1, 1, 32'h13,       0, 32'h0,        1,  0, 32'h80000000, 0, 32'h0,        32'h0);
    add(0, 1, 0, 32'h0,        0, 32'h0,        1,  0, 32'h80000000, 1, 32'h13,       32'h80000000);
    add(0, 1, 0, 32'h0,        0, 32'h0,        1,  1, 32'h80000004, 0, 32'h0,        32'h0);
    add(0, 1, 1, 32'h13,       0, 32'h0,        1,  0, 32'h80000004, 0, 32'h0,        32'h0);
    add(0, 1, 0, 32'h0,        0, 32'h0,        1,  0, 32'h80000004, 1, 32'h13,       32'h80000004);
    add(0, 1, 0, 32'h0,        0, 32'h0,        1,  1, 32'h80000008, 0, 32'h0,        32'h0);
    // backpressure for 4 cycles
    add(0, 1, 1, 32'h00100093, 0, 32'h0,        0,  0, 32'h80000008, 0, 32'h0,        32'h0);
    for (int i = 0; i < 4; i++)
      add(0, 1, 0, 32'h0,      0, 32'h0,        0,  0, 32'h80000008, 1, 32'h00100093, 32'h80000008);
    add(0, 1, 0, 32'h0,        0, 32'h0,        1,  0, 32'h80000008, 1, 32'h00100093, 32'h80000008);
    add(0, 1, 0, 32'h0,        0, 32'h0,        1,  1, 32'h8000000C, 0, 32'h0,        32'h0);
    // redirect in WAIT, stale response 2 cycles later
    add(0, 1, 0, 32'h0,        1, 32'h80000100, 1,  0, 32'h8000000C, 0, 32'h0,        32'h0);
    add(0, 1, 0, 32'h0,        0, 32'h0,        1,  0, 32'h80000100, 0, 32'h0,        32'h0);
    add(0, 1, 1, 32'hDEADBEEF, 0, 32'h0,        1,  0, 32'h80000100, 0, 32'h0,        32'h0);
    add(0, 1, 0, 32'h0,        0, 32'h0,        1,  1, 32'h80000100, 0, 32'h0,        32'h0);
    add(0, 1, 1, 32'h00000513, 0, 32'h0,        1,  0, 32'h80000100, 0, 32'h0,        32'h0);
    add(0, 1, 0, 32'h0,        0, 32'h0,        1,  0, 32'h80000100, 1, 32'h00000513, 32'h80000100);
    // redirect in HOLD with inst_ready=1
    add(0, 1, 0, 32'h0,        0, 32'h0,        1,  1, 32'h80000104, 0, 32'h0,        32'h0);
    add(0, 1, 1, 32'h11111111, 0, 32'h0,        1,  0, 32'h80000104, 0, 32'h0,        32'h0);
    add(0, 1, 0, 32'h0,        1, 32'h80000040, 1,  0, 32'h80000104, 0, 32'h0,        32'h0);
    add(0, 1, 0, 32'h0,        0, 32'h0,        1,  1, 32'h80000040, 0, 32'h0,        32'h0);
    add(0, 1, 1, 32'h22222222, 0, 32'h0,        1,  0, 32'h80000040, 0, 32'h0,        32'h0);
    add(0, 1, 0, 32'h0,        0, 32'h0,        1,  0, 32'h80000040, 1, 32'h22222222, 32'h80000040);
    // response while in REQ is ignored
    add(0, 0, 1, 32'h33333333, 0, 32'h0,        1,  1, 32'h80000044, 0, 32'h0,        32'h0);
    add(0, 1, 0, 32'h0,        0, 32'h0,        1,  1, 32'h80000044, 0, 32'h0,        32'h0);
    add(0, 1, 1, 32'h44444444, 0, 32'h0,        1,  0, 32'h80000044, 0, 32'h0,        32'h0);
    add(0, 1, 0, 32'h0,        0, 32'h0,        1,  0, 32'h80000044, 1, 32'h44444444, 32'h80000044);
    // redirect coincident with request handshake
    add(0, 1, 0, 32'h0,        1, 32'h80000200, 1,  1, 32'h80000048, 0, 32'h0,        32'h0);
    add(0, 1, 1, 32'h55555555, 0, 32'h0,        1,  0, 32'h80000200, 0, 32'h0,        32'h0);
    add(0, 1, 0, 32'h0,        0, 32'h0,        1,  1, 32'h80000200, 0, 32'h0,        32'h0);
    add(0, 1, 1, 32'h66666666, 0, 32'h0,        1,  0, 32'h80000200, 0, 32'h0,        32'h0);
    add(0, 1, 0, 32'h0,        0, 32'h0,        1,  0, 32'h80000200, 1, 32'h66666666, 32'h80000200);
    // redirect coincident with response
    add(0, 1, 0, 32'h0,        0, 32'h0,        1,  1, 32'h80000204, 0, 32'h0,        32'h0);
    add(0, 1, 1, 32'h77777777, 1, 32'h80000300, 1,  0, 32'h80000204, 0, 32'h0,        32'h0);
    add(0, 1, 0, 32'h0,        0, 32'h0,        1,  1, 32'h80000300, 0, 32'h0,        32'h0);
    add(0, 1, 1, 32'h88888888, 0, 32'h0,        1,  0, 32'h80000300, 0, 32'h0,        32'h0);
    add(0, 1, 0, 32'h0,        0, 32'h0,        1,  0, 32'h80000300, 1, 32'h88888888, 32'h80000300);
    // redirect in REQ without handshake
    add(0, 0, 0, 32'h0,        1, 32'h80000400, 1,  1, 32'h80000304, 0, 32'h0,        32'h0);
    add(0, 1, 0, 32'h0,        0, 32'h0,        1,  1, 32'h80000400, 0, 32'h0,        32'h0);
    add(0, 1, 1, 32'h99999999, 0, 32'h0,        1,  0, 32'h80000400, 0, 32'h0,        32'h0);
    add(0, 1, 0, 32'h0,        0, 32'h0,        1,  0, 32'h80000400, 1, 32'h99999999, 32'h80000400);
    // PC wrap at 0xFFFFFFFC
    add(0, 0, 0, 32'h0,        1, 32'hFFFFFFFC, 1,  1, 32'h80000404, 0, 32'h0,        32'h0);
    add(0, 1, 0, 32'h0,        0, 32'h0,        1,  1, 32'hFFFFFFFC, 0, 32'h0,        32'h0);
    add(0, 1, 1, 32'hAAAAAAAA, 0, 32'h0,        1,  0, 32'hFFFFFFFC, 0, 32'h0,        32'h0);
    add(0, 1, 0, 32'h0,        0, 32'h0,        1,  0, 32'hFFFFFFFC, 1, 32'hAAAAAAAA, 32'hFFFFFFFC);
    add(0, 0, 0, 32'h0,        0, 32'h0,        1,  1, 32'h00000000, 0, 32'h0,        32'h0);
    foreach (vq[i]) apply(vq[i], i);

    // misaligned redirect: trap with the check enabled, truncated target otherwise
    apply('{0, 0, 0, 32'h0, 1, 32'h80000102, 1, 1, 32'h0, 0, 32'h0, 32'h0, 0}, 100);
    apply('{0, 1, 0, 32'h0, 1, 32'h80000500, 1, !ALIGN, ALIGN ? 32'h80000102 : 32'h80000100,
            0, 32'h0, 32'h0, ALIGN}, 101);
    apply('{0, 1, 0, 32'h0, 0, 32'h0, 1, 0, ALIGN ? 32'h80000102 : 32'h80000500, 0, 32'h0, 32'h0, ALIGN}, 102);
    apply('{0, 1, 1, 32'hCCCCCCCC, 0, 32'h0, 1, 0, ALIGN ? 32'h80000102 : 32'h80000500,
            0, 32'h0, 32'h0, ALIGN}, 103);
    apply('{0, 0, 0, 32'h0, 0, 32'h0, 1, !ALIGN, ALIGN ? 32'h80000102 : 32'h80000500,
            0, 32'h0, 32'h0, ALIGN}, 104);
    // reset clears everything; reset mid-WAIT drops the late response
    apply('{1, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h80000000, 0, 32'h0, 32'h0, 0}, 105);
    apply('{0, 1, 0, 32'h0, 0, 32'h0, 1, 1, 32'h80000000, 0, 32'h0, 32'h0, 0}, 106);
    apply('{1, 0, 0, 32'h0, 0, 32'h0, 1, 0, 32'h80000000, 0, 32'h0, 32'h0, 0}, 107);
    apply('{0, 0, 1, 32'hBBBBBBBB, 0, 32'h0, 1, 1, 32'h80000000, 0, 32'h0, 32'h0, 0}, 108);
    apply('{0, 0, 0, 32'h0, 0, 32'h0, 1, 1, 32'h80000000, 0, 32'h0, 32'h0, 0}, 109);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
